// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch stage
package fetch_pkg;

   localparam int          DEFAULT_PC_WIDTH  = 32;
   localparam int          DEFAULT_IMEM_AW   = 12;
   localparam int          DEFAULT_CNT_WIDTH = 16;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/adder32.sv
// rtl/adder32.sv - 32-bit ripple adder with carry-in, carry-out and signed overflow
module adder32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout,
   output logic        overflow
);

   logic [32:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
   assign sum      = full_sum[31:0];
   assign cout     = full_sum[32];
   assign overflow = (a[31] == b[31]) && (full_sum[31] != a[31]);

endmodule

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch sequencer: PC, imem address, F/D qualification, perf counters
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int                   PC_WIDTH  = DEFAULT_PC_WIDTH,
   parameter int                   IMEM_AW   = DEFAULT_IMEM_AW,
   parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(DEFAULT_RESET_PC),
   parameter int                   CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 stall_in,
   input  logic                 redirect,
   input  logic [PC_WIDTH-1:0]  redirect_pc,
   input  logic                 halt,
   output logic [IMEM_AW-1:0]   address_imem,
   output logic [4:0]           pc_upper_5,
   output logic [PC_WIDTH-1:0]  fd_pc,
   output logic                 fd_valid,
   output logic                 fd_we,
   output logic [CNT_WIDTH-1:0] fetch_count,
   output logic [CNT_WIDTH-1:0] bubble_count
);

   fetch_state_e        state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_prev_q;
   logic                issued_q;
   logic [PC_WIDTH-1:0] pc_inc;
   logic                unused_cout;
   logic                unused_ovf;

   adder32 u_pc_adder (
      .a        (pc_q),
      .b        (32'd0),
      .cin      (1'b1),
      .sum      (pc_inc),
      .cout     (unused_cout),
      .overflow (unused_ovf)
   );

   // Priority: redirect > halt > stall > advance. Halt is sticky until reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_BOOT;
         pc_q      <= RESET_PC;
         pc_prev_q <= RESET_PC;
         issued_q  <= 1'b0;
      end else if (state_q != S_HALT) begin
         if (redirect) begin
            pc_q     <= redirect_pc;
            issued_q <= 1'b0;
            state_q  <= S_RUN;
         end else if (halt) begin
            state_q <= S_HALT;
         end else if (!stall_in) begin
            pc_prev_q <= pc_q;
            pc_q      <= pc_inc;
            issued_q  <= 1'b1;
            state_q   <= S_RUN;
         end
      end
   end

   // During a stall the imem re-reads the word already tagged by fd_pc.
   assign address_imem = stall_in ? pc_prev_q[IMEM_AW-1:0] : pc_q[IMEM_AW-1:0];
   assign pc_upper_5   = pc_q[PC_WIDTH-1 -: 5];
   assign fd_pc        = pc_prev_q;
   assign fd_valid     = issued_q & ~redirect & (state_q == S_RUN);
   assign fd_we        = ~stall_in | redirect | (state_q == S_HALT);

   sat_counter #(.WIDTH(CNT_WIDTH)) u_fetch_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (fd_we & fd_valid),
      .count   (fetch_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (fd_we & ~fd_valid),
      .count   (bubble_count)
   );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
   } fd_exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall_in = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        halt = 1'b0;
   logic [11:0] address_imem;
   logic [4:0]  pc_upper_5;
   logic [31:0] fd_pc;
   logic        fd_valid;
   logic        fd_we;
   logic [15:0] fetch_count;
   logic [15:0] bubble_count;

   fd_exp_t sb_q[$];
   fd_exp_t mon_e;
   int      n_vec = 0;
   int      n_bad = 0;

   always #5 clock = ~clock;

   fetch_controller dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .stall_in     (stall_in),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .halt         (halt),
      .address_imem (address_imem),
      .pc_upper_5   (pc_upper_5),
      .fd_pc        (fd_pc),
      .fd_valid     (fd_valid),
      .fd_we        (fd_we),
      .fetch_count  (fetch_count),
      .bubble_count (bubble_count)
   );

   // Every F/D write must match the next expected entry.
   always @(negedge clock) begin
      if (reset_n && fd_we) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: fd_valid=%0b fd_pc=%h but no write expected", fd_valid, fd_pc);
         end else begin
            mon_e = sb_q.pop_front();
            if (fd_valid !== mon_e.valid || (mon_e.valid && fd_pc !== mon_e.pc)) begin
               n_bad++;
               $display("FAIL sb_fd_write: got valid=%0b pc=%h, expected valid=%0b pc=%h",
                        fd_valid, fd_pc, mon_e.valid, mon_e.pc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_v(input logic [31:0] pc);
      fd_exp_t e;
      e.valid = 1'b1;
      e.pc    = pc;
      sb_q.push_back(e);
   endtask

   task automatic push_b();
      fd_exp_t e;
      e.valid = 1'b0;
      e.pc    = 32'd0;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_vec++;
      if (fd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fd_valid: got %0b expected 0", fd_valid); end
      n_vec++;
      if (fd_pc !== 32'd0) begin n_bad++; $display("FAIL reset_fd_pc: got %h expected 0", fd_pc); end
      n_vec++;
      if (fetch_count !== 16'd0 || bubble_count !== 16'd0) begin
         n_bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", fetch_count, bubble_count);
      end
      n_vec++;
      if (address_imem !== 12'd0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", address_imem); end
   endtask

   task automatic test_sequential();
      push_b(); push_v(32'd0); push_v(32'd1); push_v(32'd2); push_v(32'd3);
      reset_n = 1'b1;
      repeat (5) tick();
      n_vec++;
      if (fetch_count !== 16'd4 || bubble_count !== 16'd1) begin
         n_bad++; $display("FAIL seq_counters: got %0d/%0d expected 4/1", fetch_count, bubble_count);
      end
      n_vec++;
      if (address_imem !== 12'd5) begin n_bad++; $display("FAIL seq_addr: got %h expected 005", address_imem); end
   endtask

   task automatic test_stall();
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_vec++;
         if (address_imem !== 12'd4 || fd_we !== 1'b0 || fd_pc !== 32'd4) begin
            n_bad++;
            $display("FAIL stall_hold: got addr=%h we=%0b pc=%h expected 004/0/4", address_imem, fd_we, fd_pc);
         end
         tick();
      end
      n_vec++;
      if (fetch_count !== 16'd4 || bubble_count !== 16'd1) begin
         n_bad++; $display("FAIL stall_counters: got %0d/%0d expected 4/1", fetch_count, bubble_count);
      end
      stall_in = 1'b0;
      push_v(32'd4); push_v(32'd5);
      tick(); tick();
      n_vec++;
      if (fetch_count !== 16'd6) begin n_bad++; $display("FAIL stall_release_count: got %0d expected 6", fetch_count); end
   endtask

   task automatic test_redirect();
      push_v(32'd6);
      tick();
      n_vec++;
      if (address_imem !== 12'd8) begin n_bad++; $display("FAIL redir_pre_addr: got %h expected 008", address_imem); end
      redirect = 1'b1; redirect_pc = 32'h40;
      push_b();
      @(negedge clock);
      n_vec++;
      if (fd_valid !== 1'b0) begin n_bad++; $display("FAIL redir_kill: got fd_valid=%0b expected 0", fd_valid); end
      tick();
      redirect = 1'b0;
      push_b();
      tick();
      n_vec++;
      if (bubble_count !== 16'd3) begin n_bad++; $display("FAIL redir_bubbles: got %0d expected 3", bubble_count); end
      push_v(32'h40); push_v(32'h41);
      tick(); tick();
      n_vec++;
      if (fetch_count !== 16'd9) begin n_bad++; $display("FAIL redir_fetch: got %0d expected 9", fetch_count); end
   endtask

   task automatic test_redirect_overrides();
      stall_in = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
      push_b();
      @(negedge clock);
      n_vec++;
      if (fd_we !== 1'b1) begin n_bad++; $display("FAIL redir_stall_we: got %0b expected 1", fd_we); end
      tick();
      stall_in = 1'b0; redirect = 1'b0;
      push_b();
      @(negedge clock);
      n_vec++;
      if (address_imem !== 12'h080) begin n_bad++; $display("FAIL redir_stall_addr: got %h expected 080", address_imem); end
      tick();
      push_v(32'h80); push_v(32'h81);
      tick(); tick();
      redirect = 1'b1; halt = 1'b1; redirect_pc = 32'h100;
      push_b();
      tick();
      redirect = 1'b0; halt = 1'b0;
      push_b(); push_v(32'h100); push_v(32'h101);
      repeat (3) tick();
      n_vec++;
      if (fetch_count !== 16'd13 || bubble_count !== 16'd7) begin
         n_bad++; $display("FAIL redir_halt_counters: got %0d/%0d expected 13/7", fetch_count, bubble_count);
      end
   endtask

   task automatic test_back_to_back();
      redirect = 1'b1; redirect_pc = 32'h200;
      push_b();
      tick();
      redirect_pc = 32'h300;
      push_b();
      tick();
      redirect = 1'b0;
      push_b(); push_v(32'h300); push_v(32'h301);
      repeat (3) tick();
      n_vec++;
      if (fetch_count !== 16'd15 || bubble_count !== 16'd10) begin
         n_bad++; $display("FAIL b2b_counters: got %0d/%0d expected 15/10", fetch_count, bubble_count);
      end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      push_b();
      tick();
      redirect = 1'b0;
      push_b();
      @(negedge clock);
      n_vec++;
      if (address_imem !== 12'hFFF || pc_upper_5 !== 5'h1F) begin
         n_bad++; $display("FAIL wrap_top: got addr=%h upper=%h expected fff/1f", address_imem, pc_upper_5);
      end
      tick();
      push_v(32'hFFFF_FFFF);
      @(negedge clock);
      n_vec++;
      if (address_imem !== 12'h000 || pc_upper_5 !== 5'h00) begin
         n_bad++; $display("FAIL wrap_zero: got addr=%h upper=%h expected 000/00", address_imem, pc_upper_5);
      end
      tick();
      push_v(32'd0);
      tick();
      n_vec++;
      if (fetch_count !== 16'd17 || bubble_count !== 16'd12) begin
         n_bad++; $display("FAIL wrap_counters: got %0d/%0d expected 17/12", fetch_count, bubble_count);
      end
   endtask

   task automatic test_halt();
      redirect = 1'b1; redirect_pc = 32'h10;
      push_b();
      tick();
      redirect = 1'b0; halt = 1'b1;
      push_b();
      tick();
      halt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_b();
         @(negedge clock);
         n_vec++;
         if (address_imem !== 12'h010 || fd_valid !== 1'b0) begin
            n_bad++; $display("FAIL halt_hold: got addr=%h valid=%0b expected 010/0", address_imem, fd_valid);
         end
         tick();
      end
      redirect = 1'b1; redirect_pc = 32'h400;
      push_b();
      tick();
      redirect = 1'b0;
      push_b();
      @(negedge clock);
      n_vec++;
      if (address_imem !== 12'h010) begin n_bad++; $display("FAIL halt_redirect_ignored: got %h expected 010", address_imem); end
      tick();
      n_vec++;
      if (fetch_count !== 16'd17 || bubble_count !== 16'd20) begin
         n_bad++; $display("FAIL halt_counters: got %0d/%0d expected 17/20", fetch_count, bubble_count);
      end
      for (int i = 0; i < 65600; i++) begin
         push_b();
         tick();
      end
      n_vec++;
      if (bubble_count !== 16'hFFFF) begin n_bad++; $display("FAIL bubble_saturate: got %h expected ffff", bubble_count); end
      push_b(); push_b(); push_b();
      repeat (3) tick();
      n_vec++;
      if (bubble_count !== 16'hFFFF || fetch_count !== 16'd17) begin
         n_bad++; $display("FAIL bubble_stick: got %h/%0d expected ffff/17", bubble_count, fetch_count);
      end
   endtask

   task automatic test_reset_restart();
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (fd_pc !== 32'd0 || fd_valid !== 1'b0 || fetch_count !== 16'd0 || bubble_count !== 16'd0) begin
         n_bad++;
         $display("FAIL rst_mid: got pc=%h valid=%0b cnt=%0d/%0d expected 0/0/0/0", fd_pc, fd_valid, fetch_count, bubble_count);
      end
      tick();
      reset_n = 1'b1;
      push_b(); push_v(32'd0); push_v(32'd1);
      repeat (3) tick();
      n_vec++;
      if (fetch_count !== 16'd2 || bubble_count !== 16'd1) begin
         n_bad++; $display("FAIL rst_restart_counters: got %0d/%0d expected 2/1", fetch_count, bubble_count);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_overrides();
      test_back_to_back();
      test_wrap();
      test_halt();
      test_reset_restart();
      n_vec++;
      if (sb_q.size() != 0) begin
         n_bad++; $display("FAIL sb_leftover: %0d expected writes never seen, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
